// File: rtl/reg_decr_2stage_valrdy.sv
// Two-stage pipelined registered decrementer with val/rdy flow control.
// Each stage registers its input and subtracts one on the register output,
// so every accepted message leaves as in_msg - 2 (mod 2^nbits).
module reg_decr_2stage_valrdy #(
    parameter int unsigned nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_msg
);

    logic             val1;
    logic             val2;
    logic [nbits-1:0] data1;
    logic [nbits-1:0] data2;
    logic [nbits-1:0] dec1;
    logic             go1;
    logic             go2;

    // Datapath decrements and handshake logic; a stage advances when it is
    // empty or the stage downstream of it is advancing.
    always_comb begin
        dec1    = data1 - {{(nbits-1){1'b0}}, 1'b1};
        out_msg = data2 - {{(nbits-1){1'b0}}, 1'b1};
        go2     = !val2 || out_rdy;
        go1     = !val1 || go2;
        in_rdy  = go1;
        out_val = val2;
    end

    // Pipeline registers; data loads only on a valid advance so bubbles never
    // overwrite held data.
    always_ff @(posedge clk) begin
        if (reset) begin
            val1  <= 1'b0;
            val2  <= 1'b0;
            data1 <= '0;
            data2 <= '0;
        end else begin
            if (go2) begin
                val2 <= val1;
                if (val1) begin
                    data2 <= dec1;
                end
            end
            if (go1) begin
                val1 <= in_val;
                if (in_val) begin
                    data1 <= in_msg;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_decr_2stage_valrdy.sv
// Self-checking bench for reg_decr_2stage_valrdy: directed vector table,
// streaming, randomized scoreboard run and a mid-stream reset.
module tb_reg_decr_2stage_valrdy;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_msg;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_msg;

    int checks   = 0;
    int failures = 0;

    reg_decr_2stage_valrdy #(.nbits(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iv;
        logic [7:0] im;
        logic       ordy;
        logic       e_irdy;
        logic       e_oval;
        logic [7:0] e_omsg;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] expv;
        logic [7:0] prev_msg;
        bit         prev_stall;
        int         sent;
        int         got;
        int         cyc;
        int         nout;

        // Basic + wrap: 05,10,01,00,02 back-to-back, then drain with bubbles.
        vecs[0]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[1]  = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[2]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h03};
        vecs[3]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0E};
        vecs[4]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 8'hFF};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFE};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
        // Bubble must not overwrite data2 (still 0x01 -> out 0x00).
        vecs[7]  = '{1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00};
        // Backpressure: 40,41 accepted, 42 held off while out_rdy=0.
        vecs[8]  = '{1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00};
        for (int i = 10; i < 15; i++) begin
            vecs[i] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 8'h3E};
        end
        vecs[15] = '{1'b1, 8'h42, 1'b1, 1'b1, 1'b1, 8'h3E};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3F};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40};

        // Reset, checked while still asserted after the first edge.
        reset   = 1'b1;
        in_val  = 1'b0;
        in_msg  = 8'h00;
        out_rdy = 1'b0;
        tick();
        chk("reset_out_val", int'(out_val), 0);
        chk("reset_in_rdy", int'(in_rdy), 1);
        chk("reset_out_msg", int'(out_msg), 'hFF);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            in_val  = vecs[i].iv;
            in_msg  = vecs[i].im;
            out_rdy = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_rdy", i), int'(in_rdy), int'(vecs[i].e_irdy));
            chk($sformatf("vec%0d_out_val", i), int'(out_val), int'(vecs[i].e_oval));
            chk($sformatf("vec%0d_out_msg", i), int'(out_msg), int'(vecs[i].e_omsg));
            tick();
        end

        // Streaming 0x20..0x2F at full rate.
        out_rdy = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_val = (i < 16);
            in_msg = 8'h20 + 8'(i);
            #1;
            chk($sformatf("stream%0d_in_rdy", i), int'(in_rdy), 1);
            if (i >= 2) begin
                chk($sformatf("stream%0d_out_val", i), int'(out_val), 1);
                chk($sformatf("stream%0d_out_msg", i), int'(out_msg), 'h1E + i - 2);
            end
            tick();
        end
        in_val = 1'b0;
        #1;
        chk("stream_drained", int'(out_val), 0);
        tick();

        // Random valid/ready with an in-order scoreboard.
        sent       = 0;
        got        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_msg   = 8'h00;
        while ((sent < 200 || q.size() > 0) && cyc < 6000) begin
            in_val  = (sent < 200) && ($urandom_range(0, 3) != 0);
            in_msg  = 8'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                chk("rnd_hold_val", int'(out_val), 1);
                chk("rnd_hold_msg", int'(out_msg), int'(prev_msg));
            end
            if (out_val && out_rdy) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_extra_out: got 0x%0h expected no output", out_msg);
                end else begin
                    expv = q.pop_front();
                    chk("rnd_data", int'(out_msg), int'(expv));
                    got++;
                end
            end
            if (in_val && in_rdy) begin
                q.push_back(in_msg - 8'd2);
                sent++;
            end
            prev_stall = out_val && !out_rdy;
            prev_msg   = out_msg;
            tick();
            cyc++;
        end
        chk("rnd_received", got, 200);
        chk("rnd_no_timeout", int'(cyc < 6000), 1);

        // Reset with a full pipeline discards in-flight messages.
        in_val  = 1'b1;
        in_msg  = 8'h50;
        out_rdy = 1'b0;
        tick();
        in_msg = 8'h51;
        tick();
        in_val = 1'b0;
        #1;
        chk("rst_full_in_rdy", int'(in_rdy), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_out_val", int'(out_val), 0);
        chk("rst_in_rdy", int'(in_rdy), 1);
        chk("rst_out_msg", int'(out_msg), 'hFF);
        in_val  = 1'b1;
        in_msg  = 8'h08;
        out_rdy = 1'b1;
        tick();
        in_val = 1'b0;
        nout   = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_val && out_rdy) begin
                nout++;
                chk("rst_next_msg", int'(out_msg), 'h06);
            end
            tick();
        end
        chk("rst_out_count", nout, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_decr_2stage_valrdy.md
# reg_decr_2stage_valrdy

Two-stage pipelined registered decrementer with latency-insensitive val/rdy handshakes on both sides. Each stage registers its input and subtracts 1 on the register output, so every accepted message leaves as `in_msg - 2` (mod 2^nbits). This is the consumer-side counterpart of the registered incrementer. A stream incremented upstream can be passed through this block and compared against the original values. It is the first block in the regincr family with flow control and backpressure.

## Interface

- `nbits`, default 8: datapath width in bits.
- `clk`, input, 1: clock; all state updates on the posedge.
- `reset`, input, 1: synchronous, active-high.
- `in_val`, input, 1: upstream has a valid message.
- `in_rdy`, output, 1: block can accept a message this cycle.
- `in_msg`, input, nbits: message to decrement.
- `out_val`, output, 1: `out_msg` is valid.
- `out_rdy`, input, 1: downstream accepts `out_msg` this cycle.
- `out_msg`, output, nbits: result, equal to `in_msg - 2` mod 2^nbits.

## Operation

- State:
  - Stage 1: `val1` and `data1[nbits]`.
  - Stage 2: `val2` and `data2[nbits]`.
- Combinational datapath:
  - `dec1 = data1 - 1` (nbits, wraps).
  - `out_msg = data2 - 1` (nbits, wraps).
- Flow control, all combinational:
  - `go2 = !val2 || out_rdy`
  - `go1 = !val1 || go2`
  - `in_rdy = go1`
  - `out_val = val2`
- Transfers:
  - Input transfer when `in_val && in_rdy`.
  - Output transfer when `out_val && out_rdy`.
- Stage 2 update when `go2`: `val2 <= val1`. If `val1`, also `data2 <= dec1`.
- Stage 2 hold when `!go2`: `val2` and `data2` keep their values.
- Stage 1 update when `go1`: `val1 <= in_val`. If `in_val`, also `data1 <= in_msg`.
- Stage 1 hold when `!go1`: `val1` and `data1` keep their values.
- Data registers load only on a valid advance. Bubbles never overwrite data.
- Arithmetic is unsigned modulo 2^nbits. There is no saturation and no flag.
  - 0x01 → 0xFF
  - 0x00 → 0xFE
  - 0x02 → 0x00
- Ordering: messages leave in strict FIFO order. None are dropped or duplicated.
- Capacity: 2 messages in flight.
- Reset:
  - `val1`, `val2`, `data1` and `data2` are cleared to 0.
  - In-flight messages are discarded, including on a reset asserted mid-stream.
  - During and after reset: `out_val=0`, `in_rdy=1`, `out_msg` = all ones (0 - 1).
- Boundary conditions:
  - Full with `out_rdy=0`: `in_rdy=0`. `out_msg` and both data registers stay stable until `out_rdy` rises.
  - Full with `out_rdy=1`: simultaneous drain and fill. `in_rdy=1`, both stages advance in the same cycle, throughput is 1 per cycle.
  - `val2=0` with `val1=1`: stage 1 advances regardless of `out_rdy`.
  - `in_val=1` with `in_rdy=0`: message is not accepted. Upstream must hold it.
  - `in_val` may drop without a transfer. The block does not require upstream stability, but downstream gets the same guarantee (`out_msg` is stable while `out_val && !out_rdy`).

## Timing

- Latency: a message accepted at posedge k appears with `out_val=1` in the cycle after posedge k+1. That is 2 cycles, minimum.
- Throughput: 1 message per cycle when `out_rdy` is held at 1.
- Combinational paths:
  - `out_rdy` → `in_rdy`, through `go2` and `go1`.
  - `data2` → `out_msg`.
  - No path from `in_msg` to any output.
- Reset: `reset` is sampled at the posedge only. The first accept can occur at the first posedge with `reset=0`.

## Test plan

- **Basic.** Send 0x05 with `out_rdy=1` → 0x03, 2 cycles after acceptance. Send 0x10 → 0x0E.
- **Wrap.** Send 0x01, 0x00, 0x02 back-to-back → 0xFF, 0xFE, 0x00 on consecutive cycles.
- **Streaming.** Send 0x20..0x2F, one per cycle, with `out_rdy=1` → 0x1E..0x2D, one per cycle, `in_rdy` never low.
- **Backpressure.**
  - Hold `out_rdy=0` and offer 0x40, 0x41, 0x42 → 0x40 and 0x41 accepted, then `in_rdy=0`.
  - `out_msg=0x3E` stays stable for 5 cycles.
  - Raise `out_rdy` → outputs 0x3E, 0x3F, 0x40 in order.
- **Random.** Random `in_val` and `out_rdy`, 200 messages → outputs match a scoreboard of `(in - 2) & 0xFF` in order. No loss and no duplication.
- **Reset mid-stream.** Pipeline full, assert `reset` for 1 cycle → `out_val=0`, `in_rdy=1`, `out_msg=0xFF`. The next message sent, 0x08, produces 0x06 only.
